// File: rtl/card_seg_pkg.sv
// Shared card-rank / 7-segment definitions for the card display encoders and readers.
// Pure constants and a combinational decode helper; no state.
package card_seg_pkg;

    typedef logic [3:0] card_t;
    typedef logic [6:0] seg_t;

    // Active-low patterns, bit 6 = segment g, bit 0 = segment a.
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_ACE   = 7'h08;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_10    = 7'h40;
    localparam seg_t SEG_JACK  = 7'h61;
    localparam seg_t SEG_QUEEN = 7'h18;
    localparam seg_t SEG_KING  = 7'h09;

    // Returns {bad, rank}; unknown patterns decode to rank 0 with bad set.
    function automatic logic [4:0] seg_to_card(input seg_t seg);
        logic [4:0] res;
        case (seg)
            SEG_BLANK: res = {1'b0, 4'd0};
            SEG_ACE:   res = {1'b0, 4'd1};
            SEG_2:     res = {1'b0, 4'd2};
            SEG_3:     res = {1'b0, 4'd3};
            SEG_4:     res = {1'b0, 4'd4};
            SEG_5:     res = {1'b0, 4'd5};
            SEG_6:     res = {1'b0, 4'd6};
            SEG_7:     res = {1'b0, 4'd7};
            SEG_8:     res = {1'b0, 4'd8};
            SEG_9:     res = {1'b0, 4'd9};
            SEG_10:    res = {1'b0, 4'd10};
            SEG_JACK:  res = {1'b0, 4'd11};
            SEG_QUEEN: res = {1'b0, 4'd12};
            SEG_KING:  res = {1'b0, 4'd13};
            default:   res = {1'b1, 4'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hex_card_reader_if.sv
// Card event handshake: one decoded digit change per accepted transfer.
// Holder of evt_valid keeps payload stable until evt_ready is seen.
interface hex_card_reader_if;
    import card_seg_pkg::*;

    logic  evt_valid;
    logic  evt_ready;
    logic  [2:0] evt_digit;
    card_t evt_card;
    logic  evt_bad;

    modport master (
        output evt_valid,
        output evt_digit,
        output evt_card,
        output evt_bad,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_digit,
        input  evt_card,
        input  evt_bad,
        output evt_ready
    );

endinterface

// File: rtl/seg_stabilizer.sv
// Glitch filter for one segment digit: pulses commit when a new pattern has been stable STABLE_CYCLES samples.
// Commit lands STABLE_CYCLES-1 edges after the pattern first appears; no backpressure.
module seg_stabilizer
    import card_seg_pkg::*;
#(
    parameter  int STABLE_CYCLES = 4,
    localparam int CW            = $clog2(STABLE_CYCLES + 1)
) (
    input  logic  slow_clock,
    input  logic  resetb,
    input  seg_t  hex,
    output logic  commit,
    output card_t rank,
    output logic  bad
);

    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);

    seg_t          sample;
    seg_t          committed;
    logic [CW-1:0] cnt;

    // The edge that would take the run length to STABLE_CYCLES is the commit edge.
    assign commit      = (hex == sample) && (cnt == CNT_ARM) && (hex != committed);
    assign {bad, rank} = seg_to_card(hex);

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            sample    <= SEG_BLANK;
            committed <= SEG_BLANK;
            cnt       <= '0;
        end else begin
            sample <= hex;
            if (hex != sample) begin
                cnt <= CW'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (commit) begin
                committed <= hex;
            end
        end
    end

endmodule

// File: rtl/hex_card_reader.sv
// Recovers card ranks from six HEX displays and reports each committed change as an event.
// Event valid one edge after commit when the output is free; stalls hold payload, later commits overwrite and flag overflow.
module hex_card_reader
    import card_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic         slow_clock,
    input  logic         resetb,
    input  seg_t         HEX0,
    input  seg_t         HEX1,
    input  seg_t         HEX2,
    input  seg_t         HEX3,
    input  seg_t         HEX4,
    input  seg_t         HEX5,
    hex_card_reader_if.master evt,
    output logic [23:0]  cards,
    output logic         overflow
);

    seg_t       hex [6];
    logic [5:0] commit;
    logic [5:0] bad_dec;
    card_t      rank [6];

    logic [5:0] pending;
    logic [5:0] bad_r;

    assign hex[0] = HEX0;
    assign hex[1] = HEX1;
    assign hex[2] = HEX2;
    assign hex[3] = HEX3;
    assign hex[4] = HEX4;
    assign hex[5] = HEX5;

    for (genvar d = 0; d < 6; d++) begin : g_dig
        seg_stabilizer #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_stab (
            .slow_clock (slow_clock),
            .resetb     (resetb),
            .hex        (hex[d]),
            .commit     (commit[d]),
            .rank       (rank[d]),
            .bad        (bad_dec[d])
        );
    end

    logic       load;
    logic       sel_found;
    logic [2:0] sel;
    logic [5:0] take;

    // Scan downwards so the lowest-index pending digit wins.
    always_comb begin
        sel_found = 1'b0;
        sel       = 3'd0;
        for (int d = 5; d >= 0; d--) begin
            if (pending[d]) begin
                sel_found = 1'b1;
                sel       = 3'(d);
            end
        end
    end

    assign load = !evt.evt_valid || evt.evt_ready;
    assign take = (load && sel_found) ? (6'b000001 << sel) : 6'b000000;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            evt.evt_valid <= 1'b0;
            evt.evt_digit <= 3'd0;
            evt.evt_card  <= 4'd0;
            evt.evt_bad   <= 1'b0;
            pending       <= 6'b0;
            bad_r         <= 6'b0;
            cards         <= 24'b0;
            overflow      <= 1'b0;
        end else begin
            if (load) begin
                if (sel_found) begin
                    evt.evt_valid <= 1'b1;
                    evt.evt_digit <= sel;
                    evt.evt_card  <= cards[{sel, 2'b00} +: 4];
                    evt.evt_bad   <= bad_r[sel];
                end else begin
                    evt.evt_valid <= 1'b0;
                end
            end
            // A same-edge load already took the old value, so that commit is not a loss.
            pending  <= (pending & ~take) | commit;
            overflow <= overflow | (|(commit & pending & ~take));
            for (int d = 0; d < 6; d++) begin
                if (commit[d]) begin
                    cards[4*d +: 4] <= rank[d];
                    bad_r[d]        <= bad_dec[d];
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_card_reader.sv
// Bench for hex_card_reader: decode table, directed corner sequences and a random run
// compared every cycle against a run-length/queue reference model.
module tb_hex_card_reader;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [6:0]  hex [6];
    logic [23:0] cards;
    logic        overflow;

    hex_card_reader_if bus();

    hex_card_reader #(.STABLE_CYCLES(S)) dut (
        .slow_clock (clk),
        .resetb     (rstb),
        .HEX0       (hex[0]),
        .HEX1       (hex[1]),
        .HEX2       (hex[2]),
        .HEX3       (hex[3]),
        .HEX4       (hex[4]),
        .HEX5       (hex[5]),
        .evt        (bus),
        .cards      (cards),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: rank is the index of the pattern in this list.
    logic [6:0] rank_pat [14] = '{7'h7F, 7'h08, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                  7'h78, 7'h00, 7'h10, 7'h40, 7'h61, 7'h18, 7'h09};

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int r = 0; r < 14; r++) begin
            if (rank_pat[r] == p) return {1'b0, 4'(r)};
        end
        return 5'h10;
    endfunction

    logic [6:0] hist [6][$];
    logic [6:0] m_comm [6];
    logic [3:0] m_cards [6];
    logic       m_bad [6];
    logic       m_pend [6];
    logic       m_vld, m_bado, m_ovf;
    logic [2:0] m_dig;
    logic [3:0] m_card;

    task automatic model_reset();
        for (int d = 0; d < 6; d++) begin
            hist[d].delete();
            m_comm[d]  = 7'h7F;
            m_cards[d] = 4'd0;
            m_bad[d]   = 1'b0;
            m_pend[d]  = 1'b0;
        end
        m_vld = 0; m_dig = 0; m_card = 0; m_bado = 0; m_ovf = 0;
    endtask

    task automatic model_step(input logic rdy);
        bit         c [6];
        logic [4:0] dec;
        int         take;
        for (int d = 0; d < 6; d++) begin
            bit all_eq;
            hist[d].push_back(hex[d]);
            if (hist[d].size() > S + 1) void'(hist[d].pop_front());
            all_eq = (hist[d].size() >= S);
            for (int j = 0; j < S; j++) begin
                if (all_eq && hist[d][hist[d].size() - 1 - j] != hex[d]) all_eq = 0;
            end
            // A run reaching exactly S: either history starts S ago or the entry before it differs.
            c[d] = all_eq && (hist[d].size() == S || hist[d][0] != hex[d]) && (hex[d] != m_comm[d]);
        end
        take = -1;
        if (!m_vld || rdy) begin
            m_vld = 0;
            for (int d = 0; d < 6; d++) begin
                if (take < 0 && m_pend[d]) begin
                    take = d;
                    m_vld = 1; m_dig = 3'(d); m_card = m_cards[d]; m_bado = m_bad[d];
                    m_pend[d] = 0;
                end
            end
        end
        for (int d = 0; d < 6; d++) begin
            if (c[d]) begin
                if (m_pend[d]) m_ovf = 1;
                dec = ref_decode(hex[d]);
                m_pend[d]  = 1;
                m_cards[d] = dec[3:0];
                m_bad[d]   = dec[4];
                m_comm[d]  = hex[d];
            end
        end
    endtask

    task automatic cycle();
        logic [33:0] act, exp;
        logic [23:0] mc;
        @(posedge clk);
        model_step(bus.evt_ready);
        #1;
        for (int d = 0; d < 6; d++) mc[4*d +: 4] = m_cards[d];
        act = {bus.evt_valid, bus.evt_valid ? {bus.evt_digit, bus.evt_card, bus.evt_bad} : 8'h0, cards, overflow};
        exp = {m_vld, m_vld ? {m_dig, m_card, m_bado} : 8'h0, mc, m_ovf};
        check("model_cycle", 64'(act), 64'(exp));
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        for (int d = 0; d < 6; d++) hex[d] = 7'h7F;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(bus.evt_valid), 0);
        check("reset_cards", 64'(cards), 0);
        check("reset_overflow", 64'(overflow), 0);
        rstb = 1'b1;
    endtask

    task automatic wait_evt();
        int found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            cycle();
            if (bus.evt_valid) found = 1;
        end
        check("evt_timeout", 64'(found), 1);
    endtask

    typedef struct {
        logic [6:0] pat;
        logic [3:0] card;
        logic       bad;
    } vec_t;
    vec_t tbl [16];

    initial begin
        int pulses, first, held;

        tbl[0]  = '{7'h08, 4'd1,  1'b0};  tbl[1]  = '{7'h24, 4'd2,  1'b0};
        tbl[2]  = '{7'h30, 4'd3,  1'b0};  tbl[3]  = '{7'h19, 4'd4,  1'b0};
        tbl[4]  = '{7'h12, 4'd5,  1'b0};  tbl[5]  = '{7'h02, 4'd6,  1'b0};
        tbl[6]  = '{7'h78, 4'd7,  1'b0};  tbl[7]  = '{7'h00, 4'd8,  1'b0};
        tbl[8]  = '{7'h10, 4'd9,  1'b0};  tbl[9]  = '{7'h40, 4'd10, 1'b0};
        tbl[10] = '{7'h61, 4'd11, 1'b0};  tbl[11] = '{7'h18, 4'd12, 1'b0};
        tbl[12] = '{7'h09, 4'd13, 1'b0};  tbl[13] = '{7'h55, 4'd0,  1'b1};
        tbl[14] = '{7'h01, 4'd0,  1'b1};  tbl[15] = '{7'h7F, 4'd0,  1'b0};

        bus.evt_ready = 1'b1;
        do_reset();

        // Idle after reset.
        repeat (20) cycle();
        check("idle_valid", 64'(bus.evt_valid), 0);
        check("idle_cards", 64'(cards), 0);
        check("idle_overflow", 64'(overflow), 0);

        // Single event latency.
        hex[2] = 7'h08;
        pulses = 0; first = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (bus.evt_valid) begin
                pulses++;
                if (first == 0) begin
                    first = i;
                    check("ace_digit", 64'(bus.evt_digit), 2);
                    check("ace_card", 64'(bus.evt_card), 1);
                    check("ace_bad", 64'(bus.evt_bad), 0);
                end
            end
        end
        check("ace_latency_edges", 64'(first), 5);
        check("ace_pulses", 64'(pulses), 1);
        check("ace_cards_field", 64'(cards[11:8]), 1);

        // Short glitch then back to the committed pattern.
        hex[0] = 7'h24;
        repeat (3) cycle();
        hex[0] = 7'h7F;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.evt_valid) pulses++;
        end
        check("glitch_pulses", 64'(pulses), 0);
        check("glitch_cards", 64'(cards), 24'h000100);

        // Simultaneous commits under a stalled consumer.
        bus.evt_ready = 1'b0;
        hex[0] = 7'h09; hex[5] = 7'h61;
        held = 1;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            if (i >= 5 && !(bus.evt_valid && bus.evt_digit == 0 && bus.evt_card == 13 && !bus.evt_bad)) held = 0;
        end
        check("stall_hold_k", 64'(held), 1);
        bus.evt_ready = 1'b1;
        cycle();
        check("second_valid", 64'(bus.evt_valid), 1);
        check("second_digit", 64'(bus.evt_digit), 5);
        check("second_card", 64'(bus.evt_card), 11);
        cycle();
        check("drained_valid", 64'(bus.evt_valid), 0);

        // Unknown pattern.
        hex[3] = 7'h55;
        wait_evt();
        check("bad_digit", 64'(bus.evt_digit), 3);
        check("bad_card", 64'(bus.evt_card), 0);
        check("bad_flag", 64'(bus.evt_bad), 1);
        repeat (2) cycle();

        // Overwrite of an unreported value while the output is blocked.
        bus.evt_ready = 1'b0;
        hex[4] = 7'h19;
        wait_evt();
        check("block_digit", 64'(bus.evt_digit), 4);
        hex[1] = 7'h30;
        repeat (6) cycle();
        check("ovf_before", 64'(overflow), 0);
        hex[1] = 7'h40;
        repeat (6) cycle();
        check("ovf_after", 64'(overflow), 1);
        check("block_still_digit", 64'(bus.evt_digit), 4);
        bus.evt_ready = 1'b1;
        cycle();
        check("ovf_evt_digit", 64'(bus.evt_digit), 1);
        check("ovf_evt_card", 64'(bus.evt_card), 10);
        cycle();
        check("ovf_drained", 64'(bus.evt_valid), 0);

        // Full decode table.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            hex[i % 6] = tbl[i].pat;
            wait_evt();
            check("tbl_digit", 64'(bus.evt_digit), 64'(i % 6));
            check("tbl_card", 64'(bus.evt_card), 64'(tbl[i].card));
            check("tbl_bad", 64'(bus.evt_bad), 64'(tbl[i].bad));
            repeat (2) cycle();
        end

        // Reset in the middle of a stalled handshake.
        bus.evt_ready = 1'b0;
        hex[2] = 7'h12;
        wait_evt();
        #2;
        do_reset();
        bus.evt_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.evt_valid) pulses++;
        end
        check("post_reset_pulses", 64'(pulses), 0);

        // Random run against the model.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            for (int d = 0; d < 6; d++) begin
                if ($urandom_range(0, 5) == 0) hex[d] = tbl[$urandom_range(0, 15)].pat;
            end
            if (i >= 300 && i < 500) bus.evt_ready = ($urandom_range(0, 7) == 0);
            else                     bus.evt_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_card_reader.md
Name: hex_card_reader

Overview:
- Reads back the six active-low 7-segment card displays (HEX0..HEX5) produced by the card-to-segment encoders and recovers the card rank on each digit.
- Filters glitches: a pattern counts only once it has been stable for STABLE_CYCLES consecutive samples.
- Each newly committed digit value is reported as one event over a valid/ready handshake.
- Used as an on-chip self-check monitor and as the scoreboard front-end in system benches.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is committed (legal range 2..15).
- CW, $clog2(STABLE_CYCLES+1), stability counter width (derived; not overridden).

Ports:
- slow_clock  in  1  system clock; all state updates on the rising edge.
- resetb  in  1  reset, asynchronous, active-low.
- HEX0..HEX5  in  7 each  segment patterns, active-low, bit 6 = segment g, bit 0 = segment a.
- evt_ready  in  1  consumer accepts the presented event.
- evt_valid  out  1  an event is presented.
- evt_digit  out  3  digit index 0..5 of the presented event.
- evt_card  out  4  decoded rank (0 blank, 1 A, 2..10, 11 J, 12 Q, 13 K).
- evt_bad  out  1  the presented pattern is not in the decode table.
- cards  out  24  committed rank per digit; digit d occupies bits [4d+3:4d].
- overflow  out  1  sticky flag: a committed value was overwritten before it was reported.

Behaviour:
- Reset (asynchronous, resetb=0):
  - sample and committed registers = 7'h7F;
  - counters = 0; cards = 0; pending = 0;
  - evt_valid = 0, evt_digit = 0, evt_card = 0, evt_bad = 0, overflow = 0.
  - Reset mid-handshake drops the event; no event follows release while inputs are blank.
- Decode table (active-low) → rank:
  - 7'h7F → 0; 7'h08 → 1; 7'h24 → 2; 7'h30 → 3; 7'h19 → 4; 7'h12 → 5; 7'h02 → 6; 7'h78 → 7;
  - 7'h00 → 8; 7'h10 → 9; 7'h40 → 10; 7'h61 → 11; 7'h18 → 12; 7'h09 → 13.
  - Any other pattern → rank 0 with bad = 1.
- Stability, per digit, every edge:
  - sample <= HEX.
  - If HEX != sample: cnt <= 1. Otherwise cnt increments, saturating at STABLE_CYCLES.
  - Commit fires on the edge where cnt would become STABLE_CYCLES and HEX != committed:
    - committed <= HEX; cards[d] <= decoded rank; pending[d] <= 1;
    - bad_d <= 1 if the pattern is not in the table.
- Latency: a pattern first present at edge k commits at edge k+STABLE_CYCLES-1. evt_valid rises after edge k+STABLE_CYCLES if the output register is free.
- Glitch rejection: a pattern shorter than STABLE_CYCLES cycles never commits. Returning to the committed pattern produces no event.
- Output register:
  - Loads when evt_valid=0, or when evt_valid & evt_ready at the same edge.
  - Source is the lowest-index pending digit; the load clears that digit's pending bit.
  - If nothing is pending, evt_valid <= 0.
  - While evt_valid & !evt_ready, evt_digit, evt_card and evt_bad hold stable.
  - Back-to-back acceptance gives one event per cycle.
- Overflow: a commit on digit d while pending[d]=1 overwrites cards[d], keeps pending, and sets overflow (cleared only by reset).
- Same-edge load and commit on digit d: the load takes the old value, pending[d] is re-set with the new value, and overflow is not set.
- Digits are independent; simultaneous commits on several digits are all recorded.

Decomposition:
- Package card_seg_pkg holds:
  - card rank typedef (4-bit) and segment pattern typedef (7-bit);
  - localparams for the 14 active-low patterns;
  - function seg_to_card returning {bad, rank}.
  - card7seg is expected to import the same constants.
- One sub-module, seg_stabilizer, instantiated six times. It contains the sample/committed registers, counter and commit pulse, and outputs commit, rank and bad.
- Top level holds the pending vector, the priority select and the output register.

Test Plan:
- Reset with all HEX=7'h7F, run 20 cycles → evt_valid=0, cards=0, overflow=0.
- HEX2=7'h08 held 4 cycles, evt_ready=1 → single evt_valid pulse 4 edges after the first sample, evt_digit=2, evt_card=1, evt_bad=0; cards[11:8]=1.
- HEX0=7'h24 for 3 cycles then back to 7'h7F → no event, cards unchanged.
- HEX0=7'h09 and HEX5=7'h61 change on the same edge, evt_ready=0 for 10 cycles, then 1:
  - first event digit 0 card 13, held stable the whole time;
  - then digit 5 card 11 on the next edge.
- HEX3=7'h55, stable → event digit 3, evt_card=0, evt_bad=1.
- evt_ready=0; HEX1 goes 7'h30 (commit) then 7'h40 (commit) while an earlier digit-4 event blocks the output:
  - overflow=1;
  - the later digit-1 event reports card 10.
